// File: rtl/oclib_cdc_bus_sender.sv
// ---------------------------------------------------------------------------
// oclib_cdc_bus_sender
//
// Source-domain half of a toggle-based bus handshake across a clock-domain
// crossing. A word accepted on the valid/ready side is registered onto
// cdc_data and announced by flipping cdc_req. The block then waits until the
// destination's acknowledge toggle (cdc_ack, synchronized through a
// Cycles-deep flop chain) matches cdc_req before accepting another word.
//
// Parameters:
//   Width         - data bits per transfer
//   Cycles        - synchronizer depth on cdc_ack (2..10)
//   TimeoutCycles - wait-for-ack limit when the timeout is built in (>= 1)
//
// Ports:
//   clock    in          source-domain clock
//   reset    in          synchronous, active-high reset
//   in_data  in  [Width] word to send
//   in_valid in          in_data is valid
//   in_ready out         block can accept a word (registered)
//   cdc_data out [Width] data held stable while a transfer is outstanding
//   cdc_req  out         request toggle (registered)
//   cdc_ack  in          acknowledge toggle, asynchronous to clock
//   error    out         sticky wait-for-ack timeout flag
//
// Optional feature: define OC_CDC_BUS_SENDER_TIMEOUT_EN to build the
// wait-for-ack timeout counter. Without it, error is tied low.
// ---------------------------------------------------------------------------
module oclib_cdc_bus_sender #(
  parameter int Width         = 32,
  parameter int Cycles        = 3,
  parameter int TimeoutCycles = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] cdc_data,
  output logic             cdc_req,
  input  logic             cdc_ack,
  output logic             error
);

  // Elaboration-time parameter checks.
  if ((Cycles < 2) || (Cycles > 10)) begin : g_bad_cycles
    $error("oclib_cdc_bus_sender: Cycles must be in 2..10");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("oclib_cdc_bus_sender: TimeoutCycles must be >= 1");
  end

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               accept_s;
  logic               in_ready_r;
  logic               cdc_req_r;
  logic [Width-1:0]   cdc_data_r;
  logic [Cycles-1:0]  ack_pipe_r;
  logic               ack_sync_s;

  assign ack_sync_s = ack_pipe_r[Cycles-1];
  assign in_ready   = in_ready_r;
  assign cdc_req    = cdc_req_r;
  assign cdc_data   = cdc_data_r;

  // Ack synchronizer: a bare flop chain, cdc_ack feeds only the first stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_pipe_r <= {Cycles{1'b0}};
    end else begin
      ack_pipe_r <= {ack_pipe_r[Cycles-2:0], cdc_ack};
    end
  end

  // Next-state decode. A mismatch between ack_sync and cdc_req while IDLE
  // is a protocol violation by the far side and is deliberately ignored.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s     = 1'b1;
          state_next_s = WAIT_ACK;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ack_sync_s == cdc_req_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_ACK;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, ready and the crossing registers; data/req move only on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
      cdc_req_r  <= 1'b0;
      cdc_data_r <= {Width{1'b0}};
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == IDLE);
      if (accept_s) begin
        cdc_data_r <= in_data;
        cdc_req_r  <= ~cdc_req_r;
      end
    end
  end

`ifdef OC_CDC_BUS_SENDER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] wait_cnt_r;
  logic            error_r;

  assign error = error_r;

  // Wait-for-ack counter: cleared on accept, saturates at TimeoutCycles,
  // and raises a sticky error the cycle it gets there. The transfer is not
  // abandoned; only reset clears the flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= {CntW{1'b0}};
      error_r    <= 1'b0;
    end else if (accept_s) begin
      wait_cnt_r <= {CntW{1'b0}};
    end else if ((state_r == WAIT_ACK) && (wait_cnt_r != CntW'(TimeoutCycles))) begin
      wait_cnt_r <= wait_cnt_r + CntW'(1);
      if (wait_cnt_r == CntW'(TimeoutCycles - 1)) begin
        error_r <= 1'b1;
      end
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
